// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the Game Boy double-buffered frame path.
//   GB_W / GB_H   : native Game Boy frame size in pixels
//   FB_DEPTH      : number of entries in one frame_buffer RAM
//   FB_ADDR_W     : frame_buffer address width
//   wr_state_t    : writer FSM states
//   WHITE..BLACK  : 2-bit shade codes carried on the pixel path
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int GB_W      = 160;
    localparam int GB_H      = 144;
    localparam int FB_DEPTH  = GB_W * GB_H;
    localparam int FB_ADDR_W = 15;

    typedef enum logic {
        W_WAIT_VS = 1'b0,
        W_FILL    = 1'b1
    } wr_state_t;

    localparam logic [1:0] WHITE = 2'b00;
    localparam logic [1:0] LGRAY = 2'b01;
    localparam logic [1:0] DGRAY = 2'b10;
    localparam logic [1:0] BLACK = 2'b11;

endpackage

// File: rtl/fb_read_addr_gen.sv
// ---------------------------------------------------------------------------
// fb_read_addr_gen
// Turns the display raster position into a front-buffer read address for a
// 2x nearest-neighbour upscale of the Game Boy frame. Registered, one cycle
// of latency; rd_addr and rd_valid are aligned.
//   i_clk      : pixel clock
//   i_rst_b    : synchronous active-low reset
//   i_disp_x   : raster x from the sync generator
//   i_disp_y   : raster y from the sync generator
//   o_rd_addr  : frame_buffer read address (0 outside the window)
//   o_rd_valid : raster is inside the scaled window
// The row base advances by one GB line every second display line, so the
// address needs no multiplier. This relies on the raster visiting every line
// in order, which the sync generator guarantees.
// ---------------------------------------------------------------------------
module fb_read_addr_gen #(
    parameter int GB_W     = 160,
    parameter int GB_H     = 144,
    parameter int ADDR_W   = 15,
    parameter int X_OFFSET = 160,
    parameter int Y_OFFSET = 76
) (
    input  logic              i_clk,
    input  logic              i_rst_b,
    input  logic [9:0]        i_disp_x,
    input  logic [9:0]        i_disp_y,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_valid
);

    localparam logic [9:0]        X_LO     = 10'(X_OFFSET);
    localparam logic [9:0]        X_HI     = 10'(X_OFFSET + 2 * GB_W);
    localparam logic [9:0]        Y_LO     = 10'(Y_OFFSET);
    localparam logic [9:0]        Y_HI     = 10'(Y_OFFSET + 2 * GB_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(GB_W);

    logic [9:0]        r_yQ;
    logic [ADDR_W-1:0] r_rowBase;
    logic [ADDR_W-1:0] r_rdAddr;
    logic              r_rdValid;

    logic              w_xIn;
    logic              w_yIn;
    logic [9:0]        w_yRel;
    logic [9:0]        w_col;
    logic [ADDR_W-1:0] w_rowBaseNext;
    logic [ADDR_W-1:0] w_addr;

    // Window test and window-relative coordinates. The column is a plain
    // halving of the x offset, so only the row needs incremental tracking.
    always_comb begin
        w_xIn  = (i_disp_x >= X_LO) && (i_disp_x < X_HI);
        w_yIn  = (i_disp_y >= Y_LO) && (i_disp_y < Y_HI);
        w_yRel = i_disp_y - Y_LO;
        w_col  = (i_disp_x - X_LO) >> 1;
    end

    // Row base update on each new display line: cleared on the first window
    // line and outside the window, stepped by one GB line whenever an odd
    // window line has just finished (i.e. the new relative y is even).
    always_comb begin
        w_rowBaseNext = r_rowBase;
        if (i_disp_y != r_yQ) begin
            if (!w_yIn || (w_yRel == 10'd0)) begin
                w_rowBaseNext = '0;
            end else if (!w_yRel[0]) begin
                w_rowBaseNext = r_rowBase + ROW_STEP;
            end
        end
        w_addr = w_rowBaseNext + ADDR_W'(w_col);
    end

    // Registered address and valid; the freshly updated row base is used in
    // the same cycle so the first pixel of a new line is already correct.
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_yQ      <= '0;
            r_rowBase <= '0;
            r_rdAddr  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_yQ      <= i_disp_y;
            r_rowBase <= w_rowBaseNext;
            r_rdValid <= w_xIn && w_yIn;
            r_rdAddr  <= (w_xIn && w_yIn) ? w_addr : '0;
        end
    end

    assign o_rd_addr  = r_rdAddr;
    assign o_rd_valid = r_rdValid;

endmodule

// File: rtl/frame_swap_controller.sv
// ---------------------------------------------------------------------------
// frame_swap_controller
// Tear-free double-buffer sequencer between the Game Boy pixel writer and
// the DVI scan-out. Single gpuclk domain; gb_* inputs are pre-synchronised.
//   gpuclk, gpuclk_rst_b : clock, synchronous active-low reset
//   gb_vsync, gb_we, gb_pixel : GB frame boundary, pixel strobe, shade
//   disp_x, disp_y, disp_vblank : display raster position and vblank
//   front_sel   : 0 = buf0 displayed / buf1 written, 1 = the reverse
//   wr_addr, wr_data, wr_en_b0, wr_en_b1 : back-buffer write port
//   rd_addr, rd_valid : front-buffer read port (2x scaled window)
//   swap_pulse  : one cycle per buffer swap
//   wr_overflow : sticky, too many pixels in the current GB frame
// Optional build macro SWAP_STATS_EN adds swap_count and drop_count.
// ---------------------------------------------------------------------------
module frame_swap_controller
    import fb_pkg::*;
#(
    parameter int GB_W     = fb_pkg::GB_W,
    parameter int GB_H     = fb_pkg::GB_H,
    parameter int ADDR_W   = fb_pkg::FB_ADDR_W,
    parameter int X_OFFSET = 160,
    parameter int Y_OFFSET = 76
) (
    input  logic              gpuclk,
    input  logic              gpuclk_rst_b,
    input  logic              gb_vsync,
    input  logic              gb_we,
    input  logic [1:0]        gb_pixel,
    input  logic [9:0]        disp_x,
    input  logic [9:0]        disp_y,
    input  logic              disp_vblank,
    output logic              front_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic              wr_en_b0,
    output logic              wr_en_b1,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              swap_pulse,
    output logic              wr_overflow
`ifdef SWAP_STATS_EN
    ,
    output logic [15:0]       swap_count,
    output logic [15:0]       drop_count
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(GB_W * GB_H);

    wr_state_t         r_state;
    wr_state_t         w_stateNext;

    logic              r_vsQ;
    logic              r_vbQ;
    logic              r_pending;
    logic              r_frontSel;
    logic              r_swapPulse;
    logic [ADDR_W-1:0] r_wrCount;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [1:0]        r_wrData;
    logic              r_wrEnB0;
    logic              r_wrEnB1;
    logic              r_overflow;

    logic              w_vsRise;
    logic              w_vbRise;
    logic              w_frameDone;
    logic              w_fillActive;
    logic [ADDR_W-1:0] w_baseCount;
    logic              w_doWrite;
    logic              w_overflowHit;
    logic              w_swap;
    logic              w_drop;
    logic              w_frontSelNext;
    logic              w_pendingNext;

    assign w_vsRise = gb_vsync & ~r_vsQ;
    assign w_vbRise = disp_vblank & ~r_vbQ;

    // Writer state register.
    always_ff @(posedge gpuclk) begin
        if (!gpuclk_rst_b) begin
            r_state <= W_WAIT_VS;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Writer next state: the first vsync edge after reset starts filling;
    // after that every edge just starts a new frame in W_FILL.
    always_comb begin
        w_stateNext = r_state;
        if (w_vsRise) begin
            w_stateNext = W_FILL;
        end
    end

    // Writer decode. A pixel that arrives together with the vsync edge
    // belongs to the new frame, so the effective count restarts at 0 in that
    // same cycle rather than one cycle later.
    always_comb begin
        w_frameDone   = w_vsRise && (r_state == W_FILL);
        w_fillActive  = (r_state == W_FILL) || w_vsRise;
        w_baseCount   = w_vsRise ? '0 : r_wrCount;
        w_doWrite     = gb_we && w_fillActive && (w_baseCount < DEPTH_L);
        w_overflowHit = gb_we && w_fillActive && (w_baseCount >= DEPTH_L);
    end

    // Swap decision. A swap consumes the pending frame even when a new frame
    // completes in the same cycle; a completion while a frame is still
    // waiting (and no swap happens) overwrites it and counts as a drop.
    always_comb begin
        w_swap         = w_vbRise && r_pending;
        w_drop         = w_frameDone && r_pending && !w_swap;
        w_frontSelNext = r_frontSel ^ w_swap;
        w_pendingNext  = r_pending;
        if (w_swap) begin
            w_pendingNext = 1'b0;
        end else if (w_frameDone) begin
            w_pendingNext = 1'b1;
        end
    end

    // Write port and swap state. The enable is steered by the front select
    // that will be in effect when the enable is visible, so a write landing
    // on the swap cycle never hits the newly displayed buffer.
    always_ff @(posedge gpuclk) begin
        if (!gpuclk_rst_b) begin
            r_vsQ       <= 1'b0;
            r_vbQ       <= 1'b0;
            r_pending   <= 1'b0;
            r_frontSel  <= 1'b0;
            r_swapPulse <= 1'b0;
            r_wrCount   <= '0;
            r_wrAddr    <= '0;
            r_wrData    <= 2'b00;
            r_wrEnB0    <= 1'b0;
            r_wrEnB1    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_vsQ       <= gb_vsync;
            r_vbQ       <= disp_vblank;
            r_pending   <= w_pendingNext;
            r_frontSel  <= w_frontSelNext;
            r_swapPulse <= w_swap;
            r_wrData    <= gb_pixel;
            r_wrEnB0    <= w_doWrite && w_frontSelNext;
            r_wrEnB1    <= w_doWrite && !w_frontSelNext;
            if (w_doWrite) begin
                r_wrAddr  <= w_baseCount;
                r_wrCount <= w_baseCount + ADDR_W'(1);
            end else if (w_vsRise) begin
                r_wrCount <= '0;
            end
            if (w_vsRise) begin
                r_overflow <= 1'b0;
            end else if (w_overflowHit) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef SWAP_STATS_EN
    logic [15:0] r_swapCount;
    logic [15:0] r_dropCount;

    // Free-running statistics, wrapping at 16 bits.
    always_ff @(posedge gpuclk) begin
        if (!gpuclk_rst_b) begin
            r_swapCount <= '0;
            r_dropCount <= '0;
        end else begin
            if (w_swap) begin
                r_swapCount <= r_swapCount + 16'd1;
            end
            if (w_drop) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
        end
    end

    assign swap_count = r_swapCount;
    assign drop_count = r_dropCount;
`endif

    fb_read_addr_gen #(
        .GB_W     (GB_W),
        .GB_H     (GB_H),
        .ADDR_W   (ADDR_W),
        .X_OFFSET (X_OFFSET),
        .Y_OFFSET (Y_OFFSET)
    ) u_read_addr_gen (
        .i_clk      (gpuclk),
        .i_rst_b    (gpuclk_rst_b),
        .i_disp_x   (disp_x),
        .i_disp_y   (disp_y),
        .o_rd_addr  (rd_addr),
        .o_rd_valid (rd_valid)
    );

    assign front_sel   = r_frontSel;
    assign wr_addr     = r_wrAddr;
    assign wr_data     = r_wrData;
    assign wr_en_b0    = r_wrEnB0;
    assign wr_en_b1    = r_wrEnB1;
    assign swap_pulse  = r_swapPulse;
    assign wr_overflow = r_overflow;

endmodule

// File: tb/tb_frame_swap_controller.sv
// ---------------------------------------------------------------------------
// tb_frame_swap_controller
// Directed bench for frame_swap_controller: full-frame writes, overflow,
// frame drop, simultaneous vsync/vblank edges, scaled read addressing and
// mid-frame reset. Build with SWAP_STATS_EN defined to also check counters.
// ---------------------------------------------------------------------------
module tb_frame_swap_controller;
    import fb_pkg::*;

    logic        gpuclk = 1'b0;
    logic        gpuclk_rst_b;
    logic        gb_vsync;
    logic        gb_we;
    logic [1:0]  gb_pixel;
    logic [9:0]  disp_x;
    logic [9:0]  disp_y;
    logic        disp_vblank;
    logic        front_sel;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_en_b0;
    logic        wr_en_b1;
    logic [14:0] rd_addr;
    logic        rd_valid;
    logic        swap_pulse;
    logic        wr_overflow;
`ifdef SWAP_STATS_EN
    logic [15:0] swap_count;
    logic [15:0] drop_count;
`endif

    int checkCount = 0;
    int errorCount = 0;
    int b0Cnt;
    int b1Cnt;
    int addrErr;

    always #5 gpuclk = ~gpuclk;

    frame_swap_controller dut (
        .gpuclk       (gpuclk),
        .gpuclk_rst_b (gpuclk_rst_b),
        .gb_vsync     (gb_vsync),
        .gb_we        (gb_we),
        .gb_pixel     (gb_pixel),
        .disp_x       (disp_x),
        .disp_y       (disp_y),
        .disp_vblank  (disp_vblank),
        .front_sel    (front_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en_b0     (wr_en_b0),
        .wr_en_b1     (wr_en_b1),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .swap_pulse   (swap_pulse),
        .wr_overflow  (wr_overflow)
`ifdef SWAP_STATS_EN
        ,
        .swap_count   (swap_count),
        .drop_count   (drop_count)
`endif
    );

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge gpuclk);
        #1;
    endtask

    // Drive the GB-side and vblank inputs, then advance one clock.
    task automatic applyStimulus(input logic vs, input logic we,
                                 input logic [1:0] px, input logic vb);
        gb_vsync    = vs;
        gb_we       = we;
        gb_pixel    = px;
        disp_vblank = vb;
        tick();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_front_sel"}, 32'(front_sel), 0);
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 0);
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 0);
        checkOutput({tag, "_wr_en_b0"}, 32'(wr_en_b0), 0);
        checkOutput({tag, "_wr_en_b1"}, 32'(wr_en_b1), 0);
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 0);
        checkOutput({tag, "_swap_pulse"}, 32'(swap_pulse), 0);
        checkOutput({tag, "_wr_overflow"}, 32'(wr_overflow), 0);
    endtask

    task automatic readAt(input logic [9:0] x, input string tag,
                          input logic expValid, input int expAddr);
        disp_x = x;
        tick();
        checkOutput({tag, "_valid"}, 32'(rd_valid), 32'(expValid));
        checkOutput({tag, "_addr"}, 32'(rd_addr), 32'(expAddr));
    endtask

    initial begin
        gpuclk_rst_b = 1'b0;
        gb_vsync     = 1'b0;
        gb_we        = 1'b0;
        gb_pixel     = WHITE;
        disp_x       = '0;
        disp_y       = '0;
        disp_vblank  = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        gpuclk_rst_b = 1'b1;

        // Writes before the first vsync edge are discarded.
        applyStimulus(1'b0, 1'b1, BLACK, 1'b0);
        checkOutput("pre_vs_en", 32'({wr_en_b0, wr_en_b1}), 0);

        // Test 1: full frame into buf1, then swap at vblank.
        applyStimulus(1'b1, 1'b0, WHITE, 1'b0);
        b0Cnt = 0; b1Cnt = 0; addrErr = 0;
        for (int i = 0; i < 23040; i++) begin
            applyStimulus(1'b1, 1'b1, 2'(i), 1'b0);
            if (wr_en_b1) b1Cnt++;
            if (wr_en_b0) b0Cnt++;
            if (!wr_en_b1 || wr_addr !== 15'(i) || wr_data !== 2'(i)) addrErr++;
        end
        applyStimulus(1'b0, 1'b0, WHITE, 1'b0);
        checkOutput("t1_b1_pulses", b1Cnt, 23040);
        checkOutput("t1_b0_pulses", b0Cnt, 0);
        checkOutput("t1_addr_data_err", addrErr, 0);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b0);
        checkOutput("t1_no_swap_before_vb", 32'(front_sel), 0);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b1);
        checkOutput("t1_front_sel", 32'(front_sel), 1);
        checkOutput("t1_swap_pulse", 32'(swap_pulse), 1);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b1);
        checkOutput("t1_swap_pulse_end", 32'(swap_pulse), 0);
`ifdef SWAP_STATS_EN
        checkOutput("t1_swap_count", 32'(swap_count), 1);
`endif

        // Test 2: 23041 writes into buf0; the last one overflows.
        b0Cnt = 0; b1Cnt = 0;
        for (int i = 0; i < 23040; i++) begin
            applyStimulus(1'b1, 1'b1, 2'(i), 1'b1);
            if (wr_en_b0) b0Cnt++;
            if (wr_en_b1) b1Cnt++;
        end
        checkOutput("t2_b0_pulses", b0Cnt, 23040);
        checkOutput("t2_b1_pulses", b1Cnt, 0);
        checkOutput("t2_last_addr", 32'(wr_addr), 23039);
        checkOutput("t2_no_ovf_yet", 32'(wr_overflow), 0);
        applyStimulus(1'b1, 1'b1, DGRAY, 1'b1);
        checkOutput("t2_extra_en", 32'({wr_en_b0, wr_en_b1}), 0);
        checkOutput("t2_overflow", 32'(wr_overflow), 1);
        checkOutput("t2_addr_held", 32'(wr_addr), 23039);
        applyStimulus(1'b0, 1'b0, WHITE, 1'b1);
        checkOutput("t2_ovf_sticky", 32'(wr_overflow), 1);
        // Pixel coincident with vsync edge lands at address 0 of the new frame.
        applyStimulus(1'b1, 1'b1, BLACK, 1'b1);
        checkOutput("t2_ovf_cleared", 32'(wr_overflow), 0);
        checkOutput("t2_vs_we_en_b0", 32'(wr_en_b0), 1);
        checkOutput("t2_vs_we_addr", 32'(wr_addr), 0);
        checkOutput("t2_vs_we_data", 32'(wr_data), 3);
        applyStimulus(1'b1, 1'b1, LGRAY, 1'b1);
        checkOutput("t2_next_addr", 32'(wr_addr), 1);
        checkOutput("t2_next_data", 32'(wr_data), 1);

        // Test 3: second completion with a frame still pending -> drop.
        applyStimulus(1'b0, 1'b0, WHITE, 1'b0);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b0);
        checkOutput("t3_no_swap_on_drop", 32'(front_sel), 1);
`ifdef SWAP_STATS_EN
        checkOutput("t3_drop_count", 32'(drop_count), 1);
`endif
        applyStimulus(1'b0, 1'b0, WHITE, 1'b1);
        checkOutput("t3_swap_front", 32'(front_sel), 0);
        checkOutput("t3_swap_pulse", 32'(swap_pulse), 1);
        applyStimulus(1'b0, 1'b0, WHITE, 1'b0);
        applyStimulus(1'b0, 1'b0, WHITE, 1'b1);
        checkOutput("t3_only_one_swap", 32'(front_sel), 0);
        checkOutput("t3_no_pulse", 32'(swap_pulse), 0);

        // Test 4: vsync edge and vblank edge together with pending=1.
        applyStimulus(1'b1, 1'b0, WHITE, 1'b0);
        applyStimulus(1'b0, 1'b0, WHITE, 1'b0);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b1);
        checkOutput("t4_swap_front", 32'(front_sel), 1);
        checkOutput("t4_swap_pulse", 32'(swap_pulse), 1);
`ifdef SWAP_STATS_EN
        checkOutput("t4_drop_unchanged", 32'(drop_count), 1);
`endif
        applyStimulus(1'b0, 1'b0, WHITE, 1'b0);
        applyStimulus(1'b0, 1'b0, WHITE, 1'b1);
        checkOutput("t4_pending_cleared", 32'(front_sel), 1);
        // Same coincidence with pending=0: frame waits for the next vblank.
        applyStimulus(1'b0, 1'b0, WHITE, 1'b0);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b1);
        checkOutput("t4b_no_swap", 32'(front_sel), 1);
        checkOutput("t4b_no_pulse", 32'(swap_pulse), 0);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b0);
        applyStimulus(1'b1, 1'b0, WHITE, 1'b1);
        checkOutput("t4b_late_swap", 32'(front_sel), 0);
        checkOutput("t4b_late_pulse", 32'(swap_pulse), 1);
`ifdef SWAP_STATS_EN
        checkOutput("t4b_swap_count", 32'(swap_count), 4);
`endif

        // Test 6: reset mid-frame.
        applyStimulus(1'b0, 1'b1, DGRAY, 1'b0);
        checkOutput("t6_pre_write", 32'(wr_en_b1), 1);
        gpuclk_rst_b = 1'b0;
        applyStimulus(1'b0, 1'b1, BLACK, 1'b0);
        checkAllZero("t6_reset");
        gpuclk_rst_b = 1'b1;
        applyStimulus(1'b0, 1'b1, DGRAY, 1'b0);
        applyStimulus(1'b0, 1'b1, DGRAY, 1'b0);
        checkOutput("t6_ignored_en", 32'({wr_en_b0, wr_en_b1}), 0);
        applyStimulus(1'b1, 1'b1, LGRAY, 1'b0);
        checkOutput("t6_first_en", 32'(wr_en_b1), 1);
        checkOutput("t6_first_addr", 32'(wr_addr), 0);
        checkOutput("t6_first_data", 32'(wr_data), 1);
        applyStimulus(1'b0, 1'b0, WHITE, 1'b0);

        // Test 5: raster scan through the scaled window.
        for (int y = 0; y < 365; y++) begin
            disp_y = 10'(y);
            disp_x = '0;
            tick();
            if (y == 76) begin
                readAt(10'd159, "t5_x159", 1'b0, 0);
                readAt(10'd160, "t5_first", 1'b1, 0);
                readAt(10'd162, "t5_x162", 1'b1, 1);
            end
            if (y == 77) readAt(10'd163, "t5_y77", 1'b1, 1);
            if (y == 78) readAt(10'd160, "t5_y78", 1'b1, 160);
            if (y == 363) begin
                readAt(10'd479, "t5_last", 1'b1, 23039);
                readAt(10'd480, "t5_x480", 1'b0, 0);
            end
            if (y == 364) readAt(10'd200, "t5_y364", 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
